// File: rtl/in3072_out1536.sv
// -----------------------------------------------------------------------------
// in3072_out1536
//
// Width down-converter: each wide AXI-Stream beat (2*NARROW_W bits) is split
// into two narrow beats, lower half first, then upper half. This is the
// unpacking counterpart of the 1536->3072 packer. It sits between the wide
// systolic-array result/weight path and the narrow DMA/stream side.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   s_axis_tdata      wide input beat, [NARROW_W-1:0] is sent first
//   s_axis_tvalid     input valid
//   s_axis_tready     input ready
//   s_axis_tlast[1:0] bit0: packet ends on lower half, bit1: ends on upper half
//   weight_switch     sideband flag, sampled together with the wide beat
//   m_axis_tdata      narrow output beat
//   m_axis_tvalid     output valid
//   m_axis_tready     output ready
//   m_axis_tlast      last narrow beat of the packet
//   weight_switch_out one-cycle pulse after a last beat that carried weight_switch
//   state_dbg         current FSM state (0 EMPTY, 1 LO, 2 HI)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A valid source holds data/last stable and never drops valid until that
// transfer. Ready may depend combinationally on the consumer's ready, never on
// the producer's valid.
// -----------------------------------------------------------------------------
module in3072_out1536 #(
  parameter int NARROW_W = 1536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NARROW_W-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [1:0]              s_axis_tlast,
  input  logic                    weight_switch,
  output logic [NARROW_W-1:0]     m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    weight_switch_out,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2*NARROW_W-1:0]   hold_data;
  logic [1:0]              hold_last;
  logic                    hold_ws;

  logic is_lo;
  logic is_hi;
  logic fire;
  logic last_half;
  logic accept;

  // Output mux and next-state logic. The unused code 2'd3 decodes as neither
  // LO nor HI, so it behaves exactly like EMPTY and falls back to EMPTY.
  always_comb begin
    is_lo         = 1'b0;
    is_hi         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = hold_data[NARROW_W-1:0];
    m_axis_tlast  = 1'b0;
    fire          = 1'b0;
    last_half     = 1'b0;
    s_axis_tready = 1'b0;
    accept        = 1'b0;
    state_next    = state;

    is_lo = (state == ST_LO);
    is_hi = (state == ST_HI);

    m_axis_tvalid = is_lo | is_hi;
    if (is_hi) begin
      m_axis_tdata = hold_data[2*NARROW_W-1:NARROW_W];
      m_axis_tlast = hold_last[1];
    end else begin
      m_axis_tlast = is_lo & hold_last[0];
    end

    fire      = m_axis_tvalid & m_axis_tready;
    // A lower half flagged last (including the malformed 2'b11) ends the
    // packet; the upper half of that beat is simply discarded.
    last_half = is_hi | (is_lo & hold_last[0]);

    // Refill in the same cycle the final half leaves: no bubble between beats.
    s_axis_tready = ~rst & (~m_axis_tvalid | (fire & last_half));
    accept        = s_axis_tvalid & s_axis_tready;

    if (accept) begin
      state_next = ST_LO;
    end else if (fire & is_lo & ~hold_last[0]) begin
      state_next = ST_HI;
    end else if (fire | ~m_axis_tvalid) begin
      state_next = ST_EMPTY;
    end else begin
      state_next = state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_EMPTY;
      hold_data         <= '0;
      hold_last         <= 2'b00;
      hold_ws           <= 1'b0;
      weight_switch_out <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        hold_data <= s_axis_tdata;
        hold_last <= s_axis_tlast;
        hold_ws   <= weight_switch;
      end
      // m_axis_tlast is only high on the final half, so one pulse per packet.
      weight_switch_out <= fire & m_axis_tlast & hold_ws;
    end
  end

  assign state_dbg = state;

endmodule
